tl_state_ctrl: RTL

Top-level sequencing controller for the transaction-layer datapath. It generates the 4-bit `state` word consumed by the referees and FIFOs. It latches and validates the almost-full/almost-empty thresholds that configure the FIFOs, and drives the FIFO flush reset. It supervises FIFO empty/error flags to move the layer between RESET, INIT, IDLE, ACTIVE and ERROR.

---
 rtl/tl_state_pkg.sv | 21 ++
 rtl/tl_state_ctrl_idle_timer.sv | 46 ++++
 rtl/tl_state_ctrl.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/tl_state_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tl_state_pkg
//  Description : Shared state codes and width for the transaction-layer
//                controller, referees and testers.
//  Revision    : 1.0 - initial release
// ============================================================================
package tl_state_pkg;

    localparam int c_STATE_W = 4;

    typedef enum logic [c_STATE_W-1:0] {
        c_ST_RESET  = 4'd0,
        c_ST_INIT   = 4'd1,
        c_ST_IDLE   = 4'd2,
        c_ST_ACTIVE = 4'd3,
        c_ST_ERROR  = 4'd4
    } tl_state_e;

endpackage
`default_nettype wire

// File: rtl/tl_state_ctrl_idle_timer.sv
`default_nettype none
// ============================================================================
//  Module      : idle_timer
//  Description : Counts consecutive all-empty cycles; flags the edge on which
//                the count reaches IDLE_CYC.
//  Revision    : 1.0 - initial release
// ============================================================================
module idle_timer #(
    parameter int IDLE_CYC = 4
) (
    input  logic clk,
    input  logic reset_L,
    input  logic clr,
    input  logic all_empty,
    output logic expired
);

    localparam int                c_CNT_W = $clog2(IDLE_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_MAX  = c_CNT_W'(IDLE_CYC);

    logic [c_CNT_W-1:0] r_cnt_q;
    logic [c_CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt_q;
        if (clr || !all_empty) begin
            w_cnt_d = '0;
        end else if (r_cnt_q != c_MAX) begin
            w_cnt_d = r_cnt_q + 1'b1;
        end
    end

    // Expiry looks at the increment happening on this edge, so it must not
    // depend on clr (clr is derived from the next state, which uses expired).
    assign expired = all_empty && (r_cnt_q >= c_MAX - 1'b1);

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_cnt_q <= '0;
        end else begin
            r_cnt_q <= w_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tl_state_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tl_state_ctrl
//  Description : Transaction-layer sequencer: state word, FIFO threshold
//                latch, FIFO flush and sticky FIFO error record.
//  Revision    : 1.0 - initial release
// ============================================================================
module tl_state_ctrl
    import tl_state_pkg::*;
#(
    parameter int N_FIFO   = 8,
    parameter int THR_W    = 3,
    parameter int IDLE_CYC = 4
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 init,
    input  logic [THR_W-1:0]     thr_af_in,
    input  logic [THR_W-1:0]     thr_ae_in,
    input  logic [N_FIFO-1:0]    empty_f,
    input  logic [N_FIFO-1:0]    error_f,
    output logic [c_STATE_W-1:0] state,
    output logic [THR_W-1:0]     thr_af_out,
    output logic [THR_W-1:0]     thr_ae_out,
    output logic                 fifo_rst_L,
    output logic                 idle_out,
    output logic                 active_out,
    output logic                 error_out,
    output logic [N_FIFO-1:0]    error_src
);

    logic [c_STATE_W-1:0] r_state_q, w_state_d;
    logic [THR_W-1:0]     r_thr_af_q, w_thr_af_d;
    logic [THR_W-1:0]     r_thr_ae_q, w_thr_ae_d;
    logic                 r_cfg_ok_q, w_cfg_ok_d;
    logic [N_FIFO-1:0]    r_error_src_q, w_error_src_d;
    logic                 r_fifo_rst_L_q, w_fifo_rst_L_d;
    logic                 r_idle_q, w_idle_d;
    logic                 r_active_q, w_active_d;
    logic                 r_error_q, w_error_d;

    logic w_valid;
    logic w_any_err;
    logic w_all_empty;
    logic w_entry;
    logic w_expired;

    assign w_valid     = (thr_ae_in < thr_af_in) && (thr_af_in != '0);
    assign w_any_err   = |error_f;
    assign w_all_empty = &empty_f;
    assign w_entry     = (w_state_d != r_state_q);

    idle_timer #(
        .IDLE_CYC (IDLE_CYC)
    ) u_idle_timer (
        .clk       (clk),
        .reset_L   (reset_L),
        .clr       (w_entry),
        .all_empty (w_all_empty),
        .expired   (w_expired)
    );

    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_ST_RESET: w_state_d = c_ST_INIT;
            // A valid pair sampled on the leaving edge is loaded on that same
            // edge, so it qualifies the exit just like a previously stored one.
            c_ST_INIT: begin
                if (!init && (r_cfg_ok_q || w_valid)) w_state_d = c_ST_IDLE;
            end
            c_ST_IDLE: begin
                if (w_any_err)         w_state_d = c_ST_ERROR;
                else if (init)         w_state_d = c_ST_INIT;
                else if (!w_all_empty) w_state_d = c_ST_ACTIVE;
            end
            c_ST_ACTIVE: begin
                if (w_any_err)      w_state_d = c_ST_ERROR;
                else if (init)      w_state_d = c_ST_INIT;
                else if (w_expired) w_state_d = c_ST_IDLE;
            end
            c_ST_ERROR: begin
                if (!w_any_err && init) w_state_d = c_ST_INIT;
            end
            default: w_state_d = c_ST_RESET;
        endcase
    end

    always_comb begin
        w_thr_af_d    = r_thr_af_q;
        w_thr_ae_d    = r_thr_ae_q;
        w_cfg_ok_d    = r_cfg_ok_q;
        w_error_src_d = r_error_src_q;

        if (r_state_q == c_ST_INIT && w_valid) begin
            w_thr_af_d = thr_af_in;
            w_thr_ae_d = thr_ae_in;
            w_cfg_ok_d = 1'b1;
        end

        if (w_state_d == c_ST_INIT && w_entry) begin
            w_cfg_ok_d    = 1'b0;
            w_error_src_d = '0;
        end else if (w_state_d == c_ST_ERROR) begin
            w_error_src_d = r_error_src_q | error_f;
        end

        w_fifo_rst_L_d = !(w_state_d == c_ST_RESET || w_state_d == c_ST_INIT);
        w_idle_d       = (w_state_d == c_ST_IDLE);
        w_active_d     = (w_state_d == c_ST_ACTIVE);
        w_error_d      = (w_state_d == c_ST_ERROR);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state_q      <= c_ST_RESET;
            r_thr_af_q     <= '0;
            r_thr_ae_q     <= '0;
            r_cfg_ok_q     <= 1'b0;
            r_error_src_q  <= '0;
            r_fifo_rst_L_q <= 1'b0;
            r_idle_q       <= 1'b0;
            r_active_q     <= 1'b0;
            r_error_q      <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_thr_af_q     <= w_thr_af_d;
            r_thr_ae_q     <= w_thr_ae_d;
            r_cfg_ok_q     <= w_cfg_ok_d;
            r_error_src_q  <= w_error_src_d;
            r_fifo_rst_L_q <= w_fifo_rst_L_d;
            r_idle_q       <= w_idle_d;
            r_active_q     <= w_active_d;
            r_error_q      <= w_error_d;
        end
    end

    assign state      = r_state_q;
    assign thr_af_out = r_thr_af_q;
    assign thr_ae_out = r_thr_ae_q;
    assign fifo_rst_L = r_fifo_rst_L_q;
    assign idle_out   = r_idle_q;
    assign active_out = r_active_q;
    assign error_out  = r_error_q;
    assign error_src  = r_error_src_q;

endmodule
`default_nettype wire
